adain_pass_sequencer: RTL and testbench

Upstream sequencer for the AdaIN normalization unit. For each N×N feature-map channel it issues the three AdaIN pass codes in order: mean, variance/coefficients, normalize. During each pass it streams pixels from the feature-map BRAM into the datapath in lock-step with the control unit's `input_mac_en`. During the normalize pass it writes the returned normalized pixels into the output buffer.

---
 rtl/adain_pkg.sv | 25 ++
 rtl/adain_addr_counter.sv | 27 ++
 rtl/adain_pass_sequencer.sv | 139 +++++++++++++
 tb/tb_adain_pass_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adain_pkg.sv
// Shared definitions for the AdaIN pass sequencer: pass codes, sizing
// constants and the sequencer state encoding.
package adain_pkg;

    localparam int N_MAX  = 256;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        PASS_IDLE = 2'b00,
        PASS_MEAN = 2'b01,
        PASS_VAR  = 2'b10,
        PASS_NORM = 2'b11
    } pass_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_S_MEAN,
        ST_W_MEAN,
        ST_S_VAR,
        ST_W_VAR,
        ST_S_NORM,
        ST_W_NORM
    } seq_state_e;

endpackage

// File: rtl/adain_addr_counter.sv
// Clearable flat pixel counter that saturates at a programmable limit
// instead of wrapping.
module adain_addr_counter
    import adain_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         inc,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count
);

    // NOTE: clear takes priority over inc so every pass starts from address 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != limit)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/adain_pass_sequencer.sv
// Issues the mean / variance / normalize pass codes for one N x N channel,
// streams feature-map pixels to the datapath and writes normalized results.
module adain_pass_sequencer
    import adain_pkg::*;
#(
    parameter int N_MAX  = adain_pkg::N_MAX,
    parameter int DATA_W = adain_pkg::DATA_W,
    parameter int ADDR_W = $clog2(N_MAX * N_MAX)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         layer_start,
    input  logic [$clog2(N_MAX+1)-1:0]   N,
    output logic                         busy,
    output logic                         layer_done,
    output logic                         cfg_err,
    output logic [1:0]                   cu_start,
    input  logic                         cu_input_mac_en,
    input  logic                         cu_out_en,
    input  logic [1:0]                   cu_done,
    output logic                         rd_en,
    output logic [ADDR_W-1:0]            rd_addr,
    input  logic [DATA_W-1:0]            rd_data,
    output logic [DATA_W-1:0]            pix_data,
    output logic                         pix_valid,
    input  logic [DATA_W-1:0]            norm_data,
    output logic                         wr_en,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic [DATA_W-1:0]            wr_data
);

    localparam int NW = $clog2(N_MAX + 1);
    localparam logic [NW-1:0]   N_MAX_W = NW'(N_MAX);
    localparam logic [2*NW-1:0] ONE     = (2*NW)'(1);

    seq_state_e        state;
    logic [NW-1:0]     n_lat;
    logic [2*NW-1:0]   n_sq_m1;
    logic [ADDR_W-1:0] limit;
    logic [ADDR_W-1:0] rd_cnt;
    logic [ADDR_W-1:0] wr_cnt;
    logic              rd_clear;
    logic              wr_clear;
    logic              n_ok;

    assign n_sq_m1 = ({{NW{1'b0}}, n_lat} * {{NW{1'b0}}, n_lat}) - ONE;
    assign limit   = n_sq_m1[ADDR_W-1:0];
    assign n_ok    = (N != '0) && (N <= N_MAX_W);

    // Reads only count while a channel is in flight, so reset silences rd_en at once.
    assign rd_en    = cu_input_mac_en & busy;
    assign rd_addr  = rd_cnt;
    assign pix_data = rd_data;

    assign rd_clear = (state == ST_S_MEAN) || (state == ST_S_VAR) || (state == ST_S_NORM);
    assign wr_clear = (state == ST_S_NORM);

    adain_addr_counter #(.W(ADDR_W)) u_rd_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (rd_clear),
        .inc   (rd_en),
        .limit (limit),
        .count (rd_cnt)
    );

    adain_addr_counter #(.W(ADDR_W)) u_wr_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (wr_clear),
        .inc   (cu_out_en),
        .limit (limit),
        .count (wr_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            n_lat      <= '0;
            busy       <= 1'b0;
            layer_done <= 1'b0;
            cfg_err    <= 1'b0;
            cu_start   <= PASS_IDLE;
            pix_valid  <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
        end else begin
            layer_done <= 1'b0;
            cfg_err    <= 1'b0;
            cu_start   <= PASS_IDLE;
            pix_valid  <= rd_en;
            wr_en      <= cu_out_en;
            wr_addr    <= wr_cnt;
            wr_data    <= norm_data;

            case (state)
                // A start coinciding with layer_done is treated as arriving while busy.
                ST_IDLE: begin
                    if (layer_start && !layer_done) begin
                        if (n_ok) begin
                            n_lat    <= N;
                            busy     <= 1'b1;
                            cu_start <= PASS_MEAN;
                            state    <= ST_S_MEAN;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                ST_S_MEAN: state <= ST_W_MEAN;
                ST_W_MEAN: begin
                    if (cu_done == PASS_MEAN) begin
                        cu_start <= PASS_VAR;
                        state    <= ST_S_VAR;
                    end
                end
                ST_S_VAR: state <= ST_W_VAR;
                ST_W_VAR: begin
                    if (cu_done == PASS_VAR) begin
                        cu_start <= PASS_NORM;
                        state    <= ST_S_NORM;
                    end
                end
                ST_S_NORM: state <= ST_W_NORM;
                // cu_done stays at 11 for the whole normalize pass, so only the write count ends it.
                ST_W_NORM: begin
                    if (wr_en && (wr_addr == limit)) begin
                        busy       <= 1'b0;
                        layer_done <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adain_pass_sequencer.sv
// Self-checking bench: a behavioural control unit and BRAM drive the sequencer
// with random gaps and data; recorded traffic is compared with the expected channel flow.
module tb_adain_pass_sequencer;
    import adain_pkg::*;

    localparam int AW = 16;
    localparam int NW = 9;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          layer_start;
    logic [NW-1:0] n_side;
    logic          busy, layer_done, cfg_err;
    logic [1:0]    cu_start;
    logic          cu_input_mac_en, cu_out_en;
    logic [1:0]    cu_done;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data = '0;
    logic [DW-1:0] pix_data;
    logic          pix_valid;
    logic [DW-1:0] norm_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [1:0]    start_q[$];
    int            rd_q[$];
    logic [DW-1:0] pix_q[$];
    int            wr_addr_q[$];
    logic [DW-1:0] wr_data_q[$];
    int            wr_cyc_q[$];
    int            done_cyc_q[$];
    int            cfg_cnt = 0;
    logic [DW-1:0] exp_norm[$];
    int            out_cyc[$];

    adain_pass_sequencer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .layer_start     (layer_start),
        .N               (n_side),
        .busy            (busy),
        .layer_done      (layer_done),
        .cfg_err         (cfg_err),
        .cu_start        (cu_start),
        .cu_input_mac_en (cu_input_mac_en),
        .cu_out_en       (cu_out_en),
        .cu_done         (cu_done),
        .rd_en           (rd_en),
        .rd_addr         (rd_addr),
        .rd_data         (rd_data),
        .pix_data        (pix_data),
        .pix_valid       (pix_valid),
        .norm_data       (norm_data),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [DW-1:0] bram_fn(input int a);
        return DW'((a * 40503) ^ 23130);
    endfunction

    // Feature-map BRAM with one cycle of read latency.
    always @(posedge clk) if (rd_en) rd_data <= bram_fn(int'(rd_addr));

    always @(negedge clk) begin
        if (rst_n) begin
            if (cu_start != 2'b00) start_q.push_back(cu_start);
            if (rd_en) rd_q.push_back(int'(rd_addr));
            if (pix_valid) pix_q.push_back(pix_data);
            if (wr_en) begin
                wr_addr_q.push_back(int'(wr_addr));
                wr_data_q.push_back(wr_data);
                wr_cyc_q.push_back(cyc);
            end
            if (layer_done) done_cyc_q.push_back(cyc);
            if (cfg_err) cfg_cnt++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        start_q.delete(); rd_q.delete(); pix_q.delete();
        wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
        done_cyc_q.delete(); exp_norm.delete(); out_cyc.delete();
        cfg_cnt = 0;
    endtask

    task automatic start(input int n);
        layer_start = 1'b1;
        n_side = NW'(n);
        step();
        layer_start = 1'b0;
    endtask

    // Control unit consumes cnt pixels with random idle cycles in between.
    task automatic feed(input int cnt);
        int consumed = 0;
        while (consumed < cnt) begin
            step();
            cu_input_mac_en = ($urandom_range(0, 3) != 0);
            if (cu_input_mac_en) consumed++;
        end
        step();
        cu_input_mac_en = 1'b0;
    endtask

    task automatic drain(input int cnt);
        int produced = 0;
        while (produced < cnt) begin
            step();
            cu_out_en = ($urandom_range(0, 2) != 0);
            norm_data = DW'($urandom);
            if (cu_out_en) begin
                exp_norm.push_back(norm_data);
                out_cyc.push_back(cyc);
                produced++;
            end
        end
        step();
        cu_out_en = 1'b0;
    endtask

    task automatic pulse_done(input logic [1:0] code);
        repeat ($urandom_range(0, 2)) step();
        cu_done = code;
        step();
        cu_done = 2'b00;
    endtask

    task automatic verify(input int n);
        int nn = n * n;
        check("start_count", start_q.size(), 3);
        for (int i = 0; i < start_q.size() && i < 3; i++) check("start_code", start_q[i], i + 1);
        check("read_count", rd_q.size(), 3 * nn);
        for (int i = 0; i < rd_q.size(); i++) check("read_addr", rd_q[i], i % nn);
        check("pix_count", pix_q.size(), 3 * nn);
        for (int i = 0; i < pix_q.size(); i++) check("pix_data", pix_q[i], bram_fn(i % nn));
        check("write_count", wr_addr_q.size(), nn);
        for (int i = 0; i < wr_addr_q.size() && i < nn; i++) begin
            check("write_addr", wr_addr_q[i], i);
            check("write_data", wr_data_q[i], exp_norm[i]);
            check("write_latency", wr_cyc_q[i], out_cyc[i] + 1);
        end
        check("done_count", done_cyc_q.size(), 1);
        if (done_cyc_q.size() > 0 && wr_cyc_q.size() > 0)
            check("done_latency", done_cyc_q[0], wr_cyc_q[wr_cyc_q.size()-1] + 1);
        check("no_cfg_err", cfg_cnt, 0);
    endtask

    task automatic run_channel(input int n, input bit poke_busy, input bit poke_done);
        int  nn = n * n;
        bit  seen = 1'b0;
        clear_q();
        start(n);
        check("accept_latency", cu_start, 2'b01);
        check("busy_after_accept", busy, 1'b1);
        feed(nn);
        if (poke_busy) begin
            layer_start = 1'b1;
            n_side = NW'(3);
            step();
            layer_start = 1'b0;
            n_side = NW'(n);
            check("busy_start_ignored", busy, 1'b1);
            check("busy_start_no_err", cfg_err, 1'b0);
        end
        pulse_done(2'b01);
        check("var_start_latency", cu_start, 2'b10);
        feed(nn);
        pulse_done(2'b10);
        check("norm_start_latency", cu_start, 2'b11);
        cu_done = 2'b11;
        feed(nn);
        drain(nn);
        for (int i = 0; i < 8 && !seen; i++) begin
            if (layer_done) seen = 1'b1;
            else step();
        end
        check("done_seen", seen, 1'b1);
        check("busy_low_at_done", busy, 1'b0);
        cu_done = 2'b00;
        if (poke_done) begin
            layer_start = 1'b1;
            n_side = NW'(2);
        end
        step();
        layer_start = 1'b0;
        if (poke_done) begin
            check("start_at_done_busy", busy, 1'b0);
            check("start_at_done_code", cu_start, 2'b00);
        end
        step();
        verify(n);
    endtask

    task automatic cfg_reject(input int nv);
        clear_q();
        start(nv);
        check("cfg_err_pulse", cfg_err, 1'b1);
        check("cfg_busy", busy, 1'b0);
        check("cfg_cu_start", cu_start, 2'b00);
        step();
        check("cfg_err_single", cfg_err, 1'b0);
        repeat (3) step();
        check("cfg_no_pass", start_q.size(), 0);
        check("cfg_err_count", cfg_cnt, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        layer_start = 1'b0;
        n_side = '0;
        cu_input_mac_en = 1'b0;
        cu_out_en = 1'b0;
        cu_done = 2'b00;
        norm_data = '0;
        #12;
        check("rst_busy", busy, 1'b0);
        check("rst_done", layer_done, 1'b0);
        check("rst_cfg_err", cfg_err, 1'b0);
        check("rst_cu_start", cu_start, 2'b00);
        check("rst_rd_en", rd_en, 1'b0);
        check("rst_pix_valid", pix_valid, 1'b0);
        check("rst_wr_en", wr_en, 1'b0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        step();
        rst_n = 1'b1;
        step();

        run_channel(4, 1'b0, 1'b1);
        run_channel(1, 1'b0, 1'b0);
        cfg_reject(0);
        cfg_reject(N_MAX + 1);
        run_channel(4, 1'b1, 1'b0);

        // Reset in the middle of the variance pass at N=8.
        clear_q();
        start(8);
        feed(64);
        pulse_done(2'b01);
        check("rst_test_var_start", cu_start, 2'b10);
        for (int i = 0; i < 10; i++) begin
            step();
            cu_input_mac_en = 1'b1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_rd_en", rd_en, 1'b0);
        check("midrst_rd_addr", rd_addr, 0);
        check("midrst_cu_start", cu_start, 2'b00);
        check("midrst_pix_valid", pix_valid, 1'b0);
        check("midrst_wr_en", wr_en, 1'b0);
        check("midrst_done", layer_done, 1'b0);
        cu_input_mac_en = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (5) step();
        check("midrst_no_done", done_cyc_q.size(), 0);
        check("midrst_idle", busy, 1'b0);

        run_channel(2, 1'b0, 1'b0);
        run_channel(3, 1'b0, 1'b0);
        run_channel(16, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
